// File: rtl/count_sequence_checker_pkg.sv
// Shared types for the count sequence checker: FSM states, step classes,
// and the step classification helper.
package count_chk_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2,
      ERROR   = 2'd3
   } chk_state_t;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      STEP = 2'd1,
      WRAP = 2'd2,
      BAD  = 2'd3
   } step_t;

   // WRAP is tested before STEP so that MAX->0 is reported as the wrap subset.
   function automatic step_t classify_step(input int unsigned cur,
                                           input int unsigned prev,
                                           input int unsigned max_val);
      step_t res;
      if (cur == prev) begin
         res = HOLD;
      end else if ((prev == max_val) && (cur == 32'd0)) begin
         res = WRAP;
      end else if (cur == (prev + 32'd1)) begin
         res = STEP;
      end else begin
         res = BAD;
      end
      return res;
   endfunction

endpackage

// File: rtl/count_sequence_checker_sync2.sv
// Two-flop synchroniser of parameterised width with synchronous active-high reset.
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Resynchronises the ripple counter value and checks successive samples for a legal
// count sequence. Optional stall detection is built when COUNT_SEQ_STALL_CHECK_EN is defined.
module count_sequence_checker
   import count_chk_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int WRAP_CNT_W  = 8,
   parameter int ERR_CNT_W   = 4,
   parameter int STALL_LIMIT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH-1:0]      q_in,
   input  logic                  cnt_reset,
   input  logic                  enable,
   input  logic                  err_clr,
   output logic [WIDTH-1:0]      q_sync,
   output logic                  locked,
   output logic                  wrap_pulse,
   output logic [WRAP_CNT_W-1:0] wrap_count,
   output logic                  seq_err,
   output logic [ERR_CNT_W-1:0]  err_count
);

   localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

   logic [WIDTH-1:0]      s2;
   logic                  cr2;
   logic [WIDTH-1:0]      s3_q, s3_d;
   chk_state_t            state_q, state_d;
   logic                  locked_q, locked_d;
   logic                  wrap_pulse_q, wrap_pulse_d;
   logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
   logic                  seq_err_q, seq_err_d;
   logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
   logic                  bad_hit;
   logic                  stall_hit;
   step_t                 step;

   sync2 #(.W(WIDTH)) u_q_sync (
      .clk   (clk),
      .reset (reset),
      .d     (q_in),
      .q     (s2)
   );

   sync2 #(.W(1)) u_cr_sync (
      .clk   (clk),
      .reset (reset),
      .d     (cnt_reset),
      .q     (cr2)
   );

   assign step = classify_step(32'(s2), 32'(s3_q), 32'(MAX_VAL));

`ifdef COUNT_SEQ_STALL_CHECK_EN
   localparam int STALL_W = $clog2(STALL_LIMIT + 1);
   logic [STALL_W-1:0] stall_q, stall_d;

   assign stall_hit = (step == HOLD) && (stall_q == STALL_W'(STALL_LIMIT - 1));

   // Consecutive-hold counter, live only while tracking undisturbed.
   always_comb begin
      stall_d = '0;
      if (enable && !cr2 && (state_q == TRACK) && (step == HOLD) && !stall_hit) begin
         stall_d = stall_q + STALL_W'(1);
      end else begin
         stall_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end
`else
   assign stall_hit = 1'b0;
`endif

   // Next-state, wrap and error bookkeeping; enable and counter reset pre-empt checking.
   always_comb begin
      state_d      = state_q;
      s3_d         = s2;
      wrap_pulse_d = 1'b0;
      wrap_count_d = wrap_count_q;
      bad_hit      = 1'b0;
      if (!enable) begin
         state_d = IDLE;
      end else if (cr2) begin
         state_d = ACQUIRE;
      end else begin
         case (state_q)
            IDLE:    state_d = ACQUIRE;
            ACQUIRE: state_d = TRACK;
            TRACK: begin
               if ((step == BAD) || stall_hit) begin
                  state_d = ERROR;
                  bad_hit = 1'b1;
               end else if (step == WRAP) begin
                  state_d      = TRACK;
                  wrap_pulse_d = 1'b1;
                  if (wrap_count_q != {WRAP_CNT_W{1'b1}}) begin
                     wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
                  end else begin
                     wrap_count_d = wrap_count_q;
                  end
               end else begin
                  state_d = TRACK;
               end
            end
            ERROR:   state_d = ACQUIRE;
            default: state_d = IDLE;
         endcase
      end

      if (bad_hit) begin
         seq_err_d = 1'b1;
         if (err_clr) begin
            err_count_d = ERR_CNT_W'(1);
         end else if (err_count_q != {ERR_CNT_W{1'b1}}) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
         end else begin
            err_count_d = err_count_q;
         end
      end else if (err_clr) begin
         seq_err_d   = 1'b0;
         err_count_d = '0;
      end else begin
         seq_err_d   = seq_err_q;
         err_count_d = err_count_q;
      end

      locked_d = (state_d == TRACK);
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         s3_q         <= '0;
         locked_q     <= 1'b0;
         wrap_pulse_q <= 1'b0;
         wrap_count_q <= '0;
         seq_err_q    <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         s3_q         <= s3_d;
         locked_q     <= locked_d;
         wrap_pulse_q <= wrap_pulse_d;
         wrap_count_q <= wrap_count_d;
         seq_err_q    <= seq_err_d;
         err_count_q  <= err_count_d;
      end
   end

   assign q_sync     = s2;
   assign locked     = locked_q;
   assign wrap_pulse = wrap_pulse_q;
   assign wrap_count = wrap_count_q;
   assign seq_err    = seq_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_count_sequence_checker.sv
// Scoreboard bench for count_sequence_checker: a behavioural model predicts each cycle's
// outputs into a queue, and a monitor pops and compares after every rising edge.
module tb_count_sequence_checker;

   localparam int W    = 4;
   localparam int WCW  = 4;
   localparam int ECW  = 4;
   localparam int MOD  = 1 << W;
   localparam int WMAX = (1 << WCW) - 1;
   localparam int EMAX = (1 << ECW) - 1;
   localparam int M_IDLE = 0, M_ACQ = 1, M_TRK = 2, M_ERR = 3;
`ifdef COUNT_SEQ_STALL_CHECK_EN
   localparam int SL = 16;
   localparam int STALL_ON = 1;
`else
   localparam int STALL_ON = 0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [W-1:0]   q_in;
   logic           cnt_reset;
   logic           enable;
   logic           err_clr;
   logic [W-1:0]   q_sync;
   logic           locked;
   logic           wrap_pulse;
   logic [WCW-1:0] wrap_count;
   logic           seq_err;
   logic [ECW-1:0] err_count;

   initial forever #5 clk = ~clk;

   count_sequence_checker #(
      .WIDTH       (W),
      .WRAP_CNT_W  (WCW),
      .ERR_CNT_W   (ECW),
      .STALL_LIMIT (16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .q_in       (q_in),
      .cnt_reset  (cnt_reset),
      .enable     (enable),
      .err_clr    (err_clr),
      .q_sync     (q_sync),
      .locked     (locked),
      .wrap_pulse (wrap_pulse),
      .wrap_count (wrap_count),
      .seq_err    (seq_err),
      .err_count  (err_count)
   );

   typedef struct {
      int q_sync;
      int locked;
      int wrap_pulse;
      int wrap_count;
      int seq_err;
      int err_count;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: samples seen by the checker, as a three-deep history of q_in.
   int hist[3];
   int crh[2];
   int m_mode, m_wc, m_ec, m_se, m_stall;
   int cur;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_edge();
      exp_t e;
      int   now_v, prev_v, diff;
      int   bad, wrap, hold, newerr, wp;
      wp = 0;
      if (reset) begin
         for (int i = 0; i < 3; i++) hist[i] = 0;
         crh[0] = 0; crh[1] = 0;
         m_mode = M_IDLE; m_wc = 0; m_ec = 0; m_se = 0; m_stall = 0;
      end else begin
         now_v  = hist[1];
         prev_v = hist[2];
         diff   = (now_v - prev_v + MOD) % MOD;
         hold   = (diff == 0);
         wrap   = (prev_v == MOD - 1) && (now_v == 0);
         bad    = (diff > 1);
         newerr = 0;
         if (!enable) begin
            m_mode = M_IDLE; m_stall = 0;
         end else if (crh[1] != 0) begin
            m_mode = M_ACQ; m_stall = 0;
         end else if (m_mode == M_TRK) begin
`ifdef COUNT_SEQ_STALL_CHECK_EN
            if (hold) begin
               m_stall++;
               if (m_stall >= SL) bad = 1;
            end else begin
               m_stall = 0;
            end
`endif
            if (bad) begin
               m_mode = M_ERR; newerr = 1; m_stall = 0;
            end else if (wrap) begin
               wp = 1;
               if (m_wc < WMAX) m_wc++;
            end
         end else begin
            m_mode  = (m_mode == M_ACQ) ? M_TRK : M_ACQ;
            m_stall = 0;
         end
         if (newerr) begin
            m_se = 1;
            m_ec = err_clr ? 1 : ((m_ec < EMAX) ? m_ec + 1 : m_ec);
         end else if (err_clr) begin
            m_se = 0; m_ec = 0;
         end
         hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(q_in);
         crh[1]  = crh[0];  crh[0]  = int'(cnt_reset);
      end
      e.q_sync     = hist[1];
      e.locked     = (m_mode == M_TRK) ? 1 : 0;
      e.wrap_pulse = wp;
      e.wrap_count = m_wc;
      e.seq_err    = m_se;
      e.err_count  = m_ec;
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit r, input int q, input bit cr, input bit en, input bit clr);
      reset     = r;
      q_in      = W'(q);
      cnt_reset = cr;
      enable    = en;
      err_clr   = clr;
      model_edge();
      @(negedge clk);
   endtask

   task automatic run(input int q, input int n);
      repeat (n) drive(1'b0, q, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic step_up(input int n, input int hold_cycles);
      for (int i = 0; i < n; i++) begin
         cur = (cur + 1) % MOD;
         run(cur, hold_cycles);
      end
   endtask

   // Monitor: every cycle is an output beat; compare against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q_sync",     int'(q_sync),     e.q_sync);
            chk("locked",     int'(locked),     e.locked);
            chk("wrap_pulse", int'(wrap_pulse), e.wrap_pulse);
            chk("wrap_count", int'(wrap_count), e.wrap_count);
            chk("seq_err",    int'(seq_err),    e.seq_err);
            chk("err_count",  int'(err_count),  e.err_count);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int q_r;
      bit cr_r, en_r, clr_r, rst_r;
      reset = 1'b1; q_in = '0; cnt_reset = 1'b0; enable = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      repeat (3) drive(1'b1, 0, 1'b0, 1'b0, 1'b0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_wrap_count", int'(wrap_count), 0);

      // Full count 0..15,0,1 at one step every two cycles.
      cur = 0;
      run(0, 2);
      step_up(17, 2);
      run(cur, 4);
      chk("count_wraps", int'(wrap_count), 1);
      chk("count_no_err", int'(seq_err), 0);
      chk("count_locked", int'(locked), 1);

      // Illegal jump 5 -> 9, then resume counting from 9.
      step_up(4, 2);
      cur = 9;
      run(cur, 2);
      step_up(3, 2);
      run(cur, 2);
      chk("jump_seq_err", int'(seq_err), 1);
      chk("jump_err_count", int'(err_count), 1);
      chk("jump_relock", int'(locked), 1);

      // Counter reset coincident with 12 -> 0: no error.
      repeat (3) drive(1'b0, 0, 1'b1, 1'b1, 1'b0);
      cur = 0;
      step_up(4, 2);
      chk("cntrst_err_count", int'(err_count), 1);
      chk("cntrst_locked", int'(locked), 1);

      // err_clr on the very cycle a bad step is classified.
      cur = (cur + 5) % MOD;
      drive(1'b0, cur, 1'b0, 1'b1, 1'b0);
      drive(1'b0, cur, 1'b0, 1'b1, 1'b0);
      drive(1'b0, cur, 1'b0, 1'b1, 1'b1);
      run(cur, 4);
      chk("clr_bad_seq_err", int'(seq_err), 1);
      chk("clr_bad_err_count", int'(err_count), 1);

      // Twenty forced bad steps saturate the error counter.
      repeat (20) begin
         cur = (cur + 5) % MOD;
         run(cur, 5);
      end
      chk("err_saturate", int'(err_count), EMAX);

      // Clear, then seventeen full wraps saturate the wrap counter.
      drive(1'b0, cur, 1'b0, 1'b1, 1'b1);
      run(cur, 3);
      step_up(17 * MOD, 1);
      run(cur, 4);
      chk("wrap_saturate", int'(wrap_count), WMAX);
      chk("wrap_no_err", int'(seq_err), 0);
      chk("wrap_err_cleared", int'(err_count), 0);

      // Long hold at 7.
      while (cur != 7) step_up(1, 1);
      run(cur, 23);
      chk("stall_seq_err", int'(seq_err), STALL_ON);

      // Reset in the middle of tracking.
      drive(1'b1, cur, 1'b0, 1'b1, 1'b0);
      chk("midrst_q_sync", int'(q_sync), 0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_wrap_count", int'(wrap_count), 0);
      chk("midrst_seq_err", int'(seq_err), 0);
      chk("midrst_err_count", int'(err_count), 0);

      // Randomised traffic.
      for (int i = 0; i < 500; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 45) begin
            q_r = cur;
         end else if (r < 92) begin
            q_r = (cur + 1) % MOD;
         end else begin
            q_r = int'($urandom_range(0, MOD - 1));
         end
         cur   = q_r;
         cr_r  = ($urandom_range(0, 49) == 0);
         en_r  = ($urandom_range(0, 59) != 0);
         clr_r = ($urandom_range(0, 29) == 0);
         rst_r = ($urandom_range(0, 199) == 0);
         drive(rst_r, cur, cr_r, en_r, clr_r);
      end

      for (int i = 0; i < 10; i++) begin
         if (exp_q.size() > 0) @(negedge clk);
      end
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
